// File: rtl/data_memory_unit_if.sv
// Bus between the ALU/control side and the data memory stage: access request,
// load result, live fault flags and the sticky fault record.
interface data_memory_unit_if;
  logic [31:0] mem_addr;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        fault_clear;
  logic [31:0] read_data;
  logic        misaligned;
  logic        addr_fault;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic [1:0]  fault_cause;

  modport master (
    output mem_addr, write_data, mem_read, mem_write, mem_size, mem_unsigned, fault_clear,
    input  read_data, misaligned, addr_fault, fault_valid, fault_addr, fault_cause
  );

  modport slave (
    input  mem_addr, write_data, mem_read, mem_write, mem_size, mem_unsigned, fault_clear,
    output read_data, misaligned, addr_fault, fault_valid, fault_addr, fault_cause
  );
endinterface

// File: rtl/data_memory_unit.sv
// Data memory stage: combinational extended loads, byte-lane stores committed on
// the clock edge, alignment/range/size checks and a first-fault sticky record.
module data_memory_unit #(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input logic               clk,
  input logic               reset,
  data_memory_unit_if.slave bus
);

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic             fault_valid_r;
  logic [31:0]      fault_addr_r;
  logic [1:0]       fault_cause_r;

  logic             act_s;
  logic             range_s;
  logic             size_s;
  logic             mis_s;
  logic             fault_s;
  logic [1:0]       cause_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       lane_s;
  logic [31:0]      word_s;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic [31:0]      ext_s;
  logic [31:0]      wmask_s;
  logic [31:0]      wdata_s;

  assign idx_s  = bus.mem_addr[IDX_W+1:2];
  assign lane_s = bus.mem_addr[1:0];
  assign word_s = mem_r[idx_s];

  // Access classification and fault cause (size beats range beats alignment).
  always_comb begin
    act_s   = bus.mem_read | bus.mem_write;
    range_s = |bus.mem_addr[31:IDX_W+2];
    size_s  = (bus.mem_size == 2'b11);
    case (bus.mem_size)
      2'b01:   mis_s = bus.mem_addr[0];
      2'b10:   mis_s = (bus.mem_addr[1:0] != 2'b00);
      default: mis_s = 1'b0;
    endcase
    fault_s = act_s & (range_s | size_s | mis_s);
    if (size_s) begin
      cause_s = 2'b11;
    end else if (range_s) begin
      cause_s = 2'b10;
    end else if (mis_s) begin
      cause_s = 2'b01;
    end else begin
      cause_s = 2'b00;
    end
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    case (lane_s)
      2'b00:   byte_s = word_s[7:0];
      2'b01:   byte_s = word_s[15:8];
      2'b10:   byte_s = word_s[23:16];
      2'b11:   byte_s = word_s[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = lane_s[1] ? word_s[31:16] : word_s[15:0];
    case (bus.mem_size)
      2'b00:   ext_s = bus.mem_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      2'b01:   ext_s = bus.mem_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      2'b10:   ext_s = word_s;
      default: ext_s = 32'h0000_0000;
    endcase
  end

  // Store lane mask with write data replicated across the lanes.
  always_comb begin
    case (bus.mem_size)
      2'b00: begin
        wmask_s = 32'h0000_00FF << {lane_s, 3'b000};
        wdata_s = {4{bus.write_data[7:0]}};
      end
      2'b01: begin
        wmask_s = lane_s[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata_s = {2{bus.write_data[15:0]}};
      end
      2'b10: begin
        wmask_s = 32'hFFFF_FFFF;
        wdata_s = bus.write_data;
      end
      default: begin
        wmask_s = 32'h0000_0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Memory array: cleared on reset, faulting stores are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (bus.mem_write && !fault_s) begin
      mem_r[idx_s] <= (word_s & ~wmask_s) | (wdata_s & wmask_s);
    end
  end

  // Sticky fault record: first fault wins; a clear beats a fault already shadowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_valid_r <= 1'b0;
      fault_addr_r  <= 32'h0000_0000;
      fault_cause_r <= 2'b00;
    end else if (fault_s && !fault_valid_r) begin
      fault_valid_r <= 1'b1;
      fault_addr_r  <= bus.mem_addr;
      fault_cause_r <= cause_s;
    end else if (bus.fault_clear) begin
      fault_valid_r <= 1'b0;
      fault_addr_r  <= 32'h0000_0000;
      fault_cause_r <= 2'b00;
    end
  end

  assign bus.read_data   = (!reset && bus.mem_read && !fault_s) ? ext_s : 32'h0000_0000;
  assign bus.misaligned  = act_s & mis_s;
  assign bus.addr_fault  = act_s & (range_s | size_s);
  assign bus.fault_valid = fault_valid_r;
  assign bus.fault_addr  = fault_addr_r;
  assign bus.fault_cause = fault_cause_r;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed table from the test plan plus random accesses, both checked against a
// byte-addressed reference model of the memory and fault record.
module tb_data_memory_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err = 0;

  data_memory_unit_if bus ();
  data_memory_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0]  mb [1024];
  logic        m_fv;
  logic [31:0] m_fa;
  logic [1:0]  m_fc;

  typedef struct {
    logic        r;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic        clr;
    logic [31:0] e_rd;
    logic        e_mis;
    logic        e_af;
    logic        e_fv;
    logic [31:0] e_fa;
    logic [1:0]  e_fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [31:0] a, logic [31:0] wd, logic rd, logic wr,
                              logic [1:0] sz, logic uns, logic clr, logic [31:0] e_rd,
                              logic e_mis, logic e_af, logic e_fv, logic [31:0] e_fa,
                              logic [1:0] e_fc);
    vec_t v;
    v.r = r; v.a = a; v.wd = wd; v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.clr = clr;
    v.e_rd = e_rd; v.e_mis = e_mis; v.e_af = e_af; v.e_fv = e_fv; v.e_fa = e_fa; v.e_fc = e_fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, logic uns);
    int n = 1 << sz;
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[a + k]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] wd,
                      input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic clr, output logic [31:0] s_rd, output logic s_mis,
                      output logic s_af, output logic s_fv, output logic [31:0] s_fa,
                      output logic [1:0] s_fc);
    logic act, rng, szf, mis, flt;
    logic [31:0] e_rd;
    logic [1:0]  cause;
    reset = r; bus.mem_addr = a; bus.write_data = wd; bus.mem_read = rd; bus.mem_write = wr;
    bus.mem_size = sz; bus.mem_unsigned = uns; bus.fault_clear = clr;
    #2;
    s_rd = bus.read_data; s_mis = bus.misaligned; s_af = bus.addr_fault;
    s_fv = bus.fault_valid; s_fa = bus.fault_addr; s_fc = bus.fault_cause;
    act = rd | wr;
    rng = (a > 32'd1023);
    szf = (sz == 2'd3);
    mis = (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    flt = act && (rng || szf || mis);
    cause = szf ? 2'd3 : (rng ? 2'd2 : 2'd1);
    e_rd = (!r && rd && !flt) ? model_load(a, sz, uns) : 32'h0;
    chk("read_data", s_rd, e_rd);
    chk("misaligned", {31'h0, s_mis}, {31'h0, act && mis});
    chk("addr_fault", {31'h0, s_af}, {31'h0, act && (rng || szf)});
    chk("fault_valid", {31'h0, s_fv}, {31'h0, m_fv});
    chk("fault_addr", s_fa, m_fa);
    chk("fault_cause", {30'h0, s_fc}, {30'h0, m_fc});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
      m_fv = 1'b0; m_fa = 32'h0; m_fc = 2'd0;
    end else begin
      if (wr && !flt) for (int k = 0; k < (1 << sz); k++) mb[a + k] = 8'(wd >> (8 * k));
      if (flt && !m_fv) begin
        m_fv = 1'b1; m_fa = a; m_fc = cause;
      end else if (clr) begin
        m_fv = 1'b0; m_fa = 32'h0; m_fc = 2'd0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] s_rd, s_fa, a;
    logic        s_mis, s_af, s_fv, r, rd, wr, uns, clr;
    logic [1:0]  s_fc, sz;

    reset = 1'b1; bus.mem_addr = 32'h0; bus.write_data = 32'h0; bus.mem_read = 1'b0;
    bus.mem_write = 1'b0; bus.mem_size = 2'd0; bus.mem_unsigned = 1'b0; bus.fault_clear = 1'b0;
    for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    m_fv = 1'b0; m_fa = 32'h0; m_fc = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    //                r     addr          wdata         rd    wr    sz    uns   clr   exp_rd        mis   af    fv    faddr         cause
    tbl.push_back(mk(1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h10, 32'h8899AABB,  1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h8899AABB, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'hFFFFFFBB, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h13, 32'h0,         1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h00000088, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h12, 32'h0,         1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'hFFFF8899, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 32'h0000AABB, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h11, 32'h000000CC,  1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h8899CCBB, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h12, 32'h00001234,  1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h1234CCBB, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h20, 32'h55667788,  1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h22, 32'hFFFFFFFF,  1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h20, 32'h0,         1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h55667788, 1'b0, 1'b0, 1'b1, 32'h22, 2'd1));
    tbl.push_back(mk(1'b0, 32'h400, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h22, 2'd1));
    tbl.push_back(mk(1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'h22, 2'd1));
    tbl.push_back(mk(1'b0, 32'h400, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h400, 2'd2));
    tbl.push_back(mk(1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'h400, 2'd2));
    tbl.push_back(mk(1'b0, 32'h02, 32'h0,         1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h404, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 32'h02, 2'd3));
    tbl.push_back(mk(1'b0, 32'h31, 32'h0,         1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h31, 2'd1));
    tbl.push_back(mk(1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'h31, 2'd1));
    tbl.push_back(mk(1'b0, 32'h30, 32'h11111111,  1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h30, 32'h22222222,  1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h30, 32'h0,         1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h22222222, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h40, 32'hDEADBEEF,  1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b1, 32'h44, 32'h12345678,  1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h40, 32'h0,         1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  2'd0));
    tbl.push_back(mk(1'b0, 32'h44, 32'h0,         1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  2'd0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].clr,
           s_rd, s_mis, s_af, s_fv, s_fa, s_fc);
      chk($sformatf("vec%0d read_data", i), s_rd, tbl[i].e_rd);
      chk($sformatf("vec%0d misaligned", i), {31'h0, s_mis}, {31'h0, tbl[i].e_mis});
      chk($sformatf("vec%0d addr_fault", i), {31'h0, s_af}, {31'h0, tbl[i].e_af});
      chk($sformatf("vec%0d fault_valid", i), {31'h0, s_fv}, {31'h0, tbl[i].e_fv});
      chk($sformatf("vec%0d fault_addr", i), s_fa, tbl[i].e_fa);
      chk($sformatf("vec%0d fault_cause", i), {30'h0, s_fc}, {30'h0, tbl[i].e_fc});
    end

    // Random traffic concentrated on a small window so loads hit earlier stores.
    for (int it = 0; it < 600; it++) begin
      r   = ($urandom_range(0, 79) == 0);
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 1023));
        default: a = 32'($urandom_range(0, 47));
      endcase
      sz  = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 5) == 0);
      step(r, a, $urandom, rd, wr, sz, uns, clr, s_rd, s_mis, s_af, s_fv, s_fa, s_fc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
